rs_age_queue: RTL and testbench
===============================

// Module: rs_age_queue
// PURPOSE
//  Parametrised unified reservation station: RS_DEPTH entries hold dispatched ops until both source operands are valid.
//  Captures operands from the CDB and issues one ready op per cycle, oldest first, to the execute stage.
//  Sits between dispatch/ROB rename and the execute issue register.
//  Frees an entry on issue, not on completion. Flushes entirely on branch mispredict.
// PARAMETERS
//  RS_DEPTH   8   number of entries (>=2, power of 2 not required)
//  TAG_W      5   ROB tag width
//  XLEN       32  operand width
//  PAYLOAD_W  64  opaque decoded-control bits carried unchanged (inst, PC, alu_func, selects, flags)
// PORTS
//  clock          in   1                  rising-edge clock
//  reset          in   1                  reset, synchronous, active-high
//  flush          in   1                  mispredict squash: invalidate all entries
//  dp_valid       in   1                  dispatch request
//  dp_ready       out  1                  at least one free entry
//  dp_tag         in   TAG_W              ROB tag of dispatched op
//  dp_rs1_rdy     in   1                  rs1 value valid at dispatch
//  dp_rs1_tag     in   TAG_W              producer tag when !dp_rs1_rdy
//  dp_rs1_value   in   XLEN               rs1 value when dp_rs1_rdy
//  dp_rs2_rdy/tag/value  in  1/TAG_W/XLEN  as rs1
//  dp_payload     in   PAYLOAD_W          control bits
//  cdb_valid      in   1                  CDB broadcast valid
//  cdb_tag        in   TAG_W              broadcast tag
//  cdb_value      in   XLEN               broadcast result
//  ex_ready       in   1                  execute accepts an op this cycle
//  is_valid       out  1                  an entry is ready to issue
//  is_tag         out  TAG_W              issued op tag
//  is_rs1_value   out  XLEN               issued rs1 operand
//  is_rs2_value   out  XLEN               issued rs2 operand
//  is_payload     out  PAYLOAD_W          issued control bits
//  free_count     out  $clog2(RS_DEPTH+1) number of free entries
// BEHAVIOUR
//  Reset: all entries invalid. dp_ready=1, is_valid=0, free_count=RS_DEPTH. Data outputs are 0 when is_valid=0.
//  Dispatch: the op is written on dp_valid&&dp_ready into the lowest-index free entry at the clock edge.
//  - dp_ready = (free_count!=0). It does not count an entry issued the same cycle.
//  Same-cycle CDB bypass: if cdb_valid and cdb_tag==dp_rsN_tag with !dp_rsN_rdy, the entry stores cdb_value as ready.
//  Wakeup: every valid entry waiting on srcN with tag==cdb_tag captures cdb_value and sets its rdy at the edge.
//  - Both sources may wake on one broadcast.
//  Issue: is_* outputs are combinational from entry state.
//  - is_valid = any valid entry with both rdy, and !flush.
//  - The selected entry is the oldest by dispatch order among the ready entries. Ties are impossible.
//  - Transfer happens when is_valid&&ex_ready. The selected entry is freed at that edge.
//  - When !ex_ready, outputs hold the same oldest-ready entry; a newly-ready older entry may preempt it.
//  Latency:
//  - Op dispatched ready at edge t is issuable in cycle t+1.
//  - Op woken by the CDB at edge t is issuable in cycle t+1. There is no CDB-to-issue combinational path.
//  Age: dispatch order is held in an age matrix or sequence counter. Dispatch order must be preserved across wrap-around of any counter.
//  Simultaneous dispatch + issue: both take effect. free_count nets to the same value.
//  Full: dp_ready=0. A dp_valid request is ignored and no state changes.
//  Flush: all entries are invalid next cycle. Dispatch and issue in the flush cycle are dropped, and is_valid=0 during flush.
//  - free_count=RS_DEPTH next cycle.
//  - Reset has priority over flush. Flush has priority over dispatch, wakeup and issue.
//  - Reset mid-operation behaves exactly like power-up reset.
//  CDB for a tag with no waiter: no effect.
// TESTING
//  T1 reset -> dp_ready=1, is_valid=0, free_count=8.
//  T2 dispatch tag3 (both rdy, 5, 7), ex_ready=1 -> next cycle is_valid=1, is_tag=3, values 5/7. Cycle after: free_count=8.
//  T3 dispatch tag4 waiting on src1 tag2. Then CDB tag2 value 0x55 -> is_valid the following cycle with is_rs1_value=0x55.
//  - Same test with CDB in the dispatch cycle -> captured via bypass.
//  T4 dispatch tags 1,2,3, all waiting on tag9, with ex_ready=0. Then CDB tag9 -> is_tag=1. Raise ex_ready -> issues 1,2,3 in order.
//  T5 fill 8 entries -> dp_ready=0. A 9th dp_valid is ignored. One issue -> dp_ready=1, the next dispatch lands in the freed index.
//  T6 flush with 5 valid, one issuing that cycle -> is_valid=0 that cycle. Next cycle free_count=8 and no stale wakeup or issue occurs.

Source files
------------

// File: rtl/rs_age_queue.sv
`default_nettype none
// ============================================================================
// Module : rs_age_queue
// Unified reservation station; operands captured from the CDB, oldest-ready
// entry issued first using an age matrix.
// Rev    : 1.0  initial release
// ============================================================================
module rs_age_queue #(
   parameter int RS_DEPTH  = 8,
   parameter int TAG_W     = 5,
   parameter int XLEN      = 32,
   parameter int PAYLOAD_W = 64
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          dp_valid,
   output logic                          dp_ready,
   input  logic [TAG_W-1:0]              dp_tag,
   input  logic                          dp_rs1_rdy,
   input  logic [TAG_W-1:0]              dp_rs1_tag,
   input  logic [XLEN-1:0]               dp_rs1_value,
   input  logic                          dp_rs2_rdy,
   input  logic [TAG_W-1:0]              dp_rs2_tag,
   input  logic [XLEN-1:0]               dp_rs2_value,
   input  logic [PAYLOAD_W-1:0]          dp_payload,
   input  logic                          cdb_valid,
   input  logic [TAG_W-1:0]              cdb_tag,
   input  logic [XLEN-1:0]               cdb_value,
   input  logic                          ex_ready,
   output logic                          is_valid,
   output logic [TAG_W-1:0]              is_tag,
   output logic [XLEN-1:0]               is_rs1_value,
   output logic [XLEN-1:0]               is_rs2_value,
   output logic [PAYLOAD_W-1:0]          is_payload,
   output logic [$clog2(RS_DEPTH+1)-1:0] free_count
);

   localparam int c_CNT_W = $clog2(RS_DEPTH+1);

   logic [RS_DEPTH-1:0]  r_valid;
   logic [RS_DEPTH-1:0]  r_rs1_rdy;
   logic [RS_DEPTH-1:0]  r_rs2_rdy;
   logic [TAG_W-1:0]     r_tag     [RS_DEPTH];
   logic [TAG_W-1:0]     r_rs1_tag [RS_DEPTH];
   logic [TAG_W-1:0]     r_rs2_tag [RS_DEPTH];
   logic [XLEN-1:0]      r_rs1_val [RS_DEPTH];
   logic [XLEN-1:0]      r_rs2_val [RS_DEPTH];
   logic [PAYLOAD_W-1:0] r_payload [RS_DEPTH];
   // r_older[i][j] set means entry i was dispatched before entry j
   logic [RS_DEPTH-1:0][RS_DEPTH-1:0] r_older;

   logic [RS_DEPTH-1:0] w_ready;
   logic [RS_DEPTH-1:0] w_sel;
   logic [RS_DEPTH-1:0] w_free;
   logic [RS_DEPTH-1:0] w_alloc;
   logic                w_dp_fire;
   logic                w_is_fire;
   logic                w_byp1;
   logic                w_byp2;

   assign w_ready = r_valid & r_rs1_rdy & r_rs2_rdy;
   assign w_free  = ~r_valid;
   // isolate the lowest set bit of w_free: lowest-index free entry
   assign w_alloc = w_free & (~w_free + {{(RS_DEPTH-1){1'b0}}, 1'b1});

   always_comb begin
      free_count = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         free_count = free_count + c_CNT_W'(w_free[i]);
      end
   end

   assign dp_ready  = (free_count != '0);
   assign is_valid  = (|w_ready) && !flush;
   assign w_dp_fire = dp_valid && dp_ready && !flush;
   assign w_is_fire = is_valid && ex_ready;
   assign w_byp1    = cdb_valid && !dp_rs1_rdy && (cdb_tag == dp_rs1_tag);
   assign w_byp2    = cdb_valid && !dp_rs2_rdy && (cdb_tag == dp_rs2_tag);

   // An entry is selected when it is ready and no older entry is ready.
   generate
      for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_sel
         logic [RS_DEPTH-1:0] w_older_ready;
         for (genvar gj = 0; gj < RS_DEPTH; gj++) begin : g_col
            assign w_older_ready[gj] = (gj != gi) && w_ready[gj] && r_older[gj][gi];
         end
         assign w_sel[gi] = w_ready[gi] && !(|w_older_ready);
      end
   endgenerate

   always_comb begin
      is_tag       = '0;
      is_rs1_value = '0;
      is_rs2_value = '0;
      is_payload   = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (is_valid && w_sel[i]) begin
            is_tag       = is_tag       | r_tag[i];
            is_rs1_value = is_rs1_value | r_rs1_val[i];
            is_rs2_value = is_rs2_value | r_rs2_val[i];
            is_payload   = is_payload   | r_payload[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_is_fire && w_sel[i]) r_valid[i] <= 1'b0;
            if (w_dp_fire && w_alloc[i]) r_valid[i] <= 1'b1;
         end
      end
   end

   // Entry contents need no reset: they are only observed through r_valid.
   always_ff @(posedge clock) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (w_dp_fire && w_alloc[i]) begin
            r_tag[i]     <= dp_tag;
            r_payload[i] <= dp_payload;
            r_rs1_tag[i] <= dp_rs1_tag;
            r_rs2_tag[i] <= dp_rs2_tag;
            r_rs1_rdy[i] <= dp_rs1_rdy || w_byp1;
            r_rs2_rdy[i] <= dp_rs2_rdy || w_byp2;
            r_rs1_val[i] <= dp_rs1_rdy ? dp_rs1_value : cdb_value;
            r_rs2_val[i] <= dp_rs2_rdy ? dp_rs2_value : cdb_value;
         end else begin
            if (cdb_valid && r_valid[i] && !r_rs1_rdy[i] && (r_rs1_tag[i] == cdb_tag)) begin
               r_rs1_rdy[i] <= 1'b1;
               r_rs1_val[i] <= cdb_value;
            end
            if (cdb_valid && r_valid[i] && !r_rs2_rdy[i] && (r_rs2_tag[i] == cdb_tag)) begin
               r_rs2_rdy[i] <= 1'b1;
               r_rs2_val[i] <= cdb_value;
            end
         end
         // newly dispatched entry becomes younger than every other entry
         for (int j = 0; j < RS_DEPTH; j++) begin
            if (w_dp_fire && w_alloc[i]) begin
               r_older[i][j] <= 1'b0;
            end else if (w_dp_fire && w_alloc[j]) begin
               r_older[i][j] <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rs_age_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_rs_age_queue
// Self-checking bench for rs_age_queue: vector table, corner sequences and
// random traffic against an age-ordered queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rs_age_queue;

   localparam int DEPTH = 8;

   typedef struct {
      bit          rst, fl, dv;
      logic [4:0]  dtag;
      bit          r1;
      logic [4:0]  t1;
      logic [31:0] v1;
      bit          r2;
      logic [4:0]  t2;
      logic [31:0] v2;
      logic [63:0] pl;
      bit          cv;
      logic [4:0]  ct;
      logic [31:0] cval;
      bit          exr;
   } in_t;

   typedef struct {
      in_t         in;
      bit          e_isv;
      logic [4:0]  e_tag;
      logic [31:0] e_v1, e_v2;
      logic [3:0]  e_fc;
      bit          e_dpr;
   } vec_t;

   typedef struct {
      logic [4:0]  tag;
      bit          r1;
      logic [4:0]  t1;
      logic [31:0] v1;
      bit          r2;
      logic [4:0]  t2;
      logic [31:0] v2;
      logic [63:0] pl;
   } ment_t;

   bit clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, flush, dp_valid, dp_ready, dp_rs1_rdy, dp_rs2_rdy;
   logic [4:0]  dp_tag, dp_rs1_tag, dp_rs2_tag, cdb_tag, is_tag;
   logic [31:0] dp_rs1_value, dp_rs2_value, cdb_value, is_rs1_value, is_rs2_value;
   logic [63:0] dp_payload, is_payload;
   logic        cdb_valid, ex_ready, is_valid;
   logic [3:0]  free_count;

   rs_age_queue #(.RS_DEPTH(DEPTH), .TAG_W(5), .XLEN(32), .PAYLOAD_W(64)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_tag(dp_tag),
      .dp_rs1_rdy(dp_rs1_rdy), .dp_rs1_tag(dp_rs1_tag), .dp_rs1_value(dp_rs1_value),
      .dp_rs2_rdy(dp_rs2_rdy), .dp_rs2_tag(dp_rs2_tag), .dp_rs2_value(dp_rs2_value),
      .dp_payload(dp_payload),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .ex_ready(ex_ready), .is_valid(is_valid), .is_tag(is_tag),
      .is_rs1_value(is_rs1_value), .is_rs2_value(is_rs2_value),
      .is_payload(is_payload), .free_count(free_count)
   );

   int    n_cmp = 0;
   int    n_err = 0;
   ment_t q[$];
   vec_t  tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pl_of(input logic [4:0] tag);
      return {32'hCAFE_0000 | {27'b0, tag}, 32'h1234_5678 ^ {27'b0, tag}};
   endfunction

   function automatic in_t nop(input bit exr);
      in_t x;
      x = '{default: '0};
      x.exr = exr;
      return x;
   endfunction

   function automatic in_t disp(input logic [4:0] tag, input logic [31:0] a, input logic [31:0] b, input bit exr);
      in_t x;
      x = nop(exr);
      x.dv = 1'b1; x.dtag = tag; x.pl = pl_of(tag);
      x.r1 = 1'b1; x.v1 = a; x.r2 = 1'b1; x.v2 = b;
      return x;
   endfunction

   function automatic vec_t mk(input bit dv, input logic [4:0] dtag,
                               input bit r1, input logic [4:0] t1, input logic [31:0] v1,
                               input bit r2, input logic [4:0] t2, input logic [31:0] v2,
                               input bit cv, input logic [4:0] ct, input logic [31:0] cval,
                               input bit exr, input bit e_isv, input logic [4:0] e_tag,
                               input logic [31:0] e_v1, input logic [31:0] e_v2,
                               input logic [3:0] e_fc, input bit e_dpr);
      vec_t v;
      v.in = nop(exr);
      v.in.dv = dv; v.in.dtag = dtag; v.in.pl = pl_of(dtag);
      v.in.r1 = r1; v.in.t1 = t1; v.in.v1 = v1;
      v.in.r2 = r2; v.in.t2 = t2; v.in.v2 = v2;
      v.in.cv = cv; v.in.ct = ct; v.in.cval = cval;
      v.e_isv = e_isv; v.e_tag = e_tag; v.e_v1 = e_v1; v.e_v2 = e_v2;
      v.e_fc = e_fc; v.e_dpr = e_dpr;
      return v;
   endfunction

   function automatic int oldest_ready();
      foreach (q[k]) if (q[k].r1 && q[k].r2) return k;
      return -1;
   endfunction

   task automatic model_check(input in_t x);
      int sel;
      bit ev;
      sel = oldest_ready();
      ev  = !x.fl && (sel >= 0);
      check("dp_ready",   dp_ready,   q.size() < DEPTH);
      check("free_count", free_count, DEPTH - q.size());
      check("is_valid",   is_valid,   ev);
      check("is_tag",     is_tag,     ev ? q[sel].tag : 0);
      check("is_rs1",     is_rs1_value, ev ? q[sel].v1 : 0);
      check("is_rs2",     is_rs2_value, ev ? q[sel].v2 : 0);
      check("is_payload", is_payload, ev ? q[sel].pl : 0);
   endtask

   task automatic model_update(input in_t x);
      int    sel;
      bit    full;
      ment_t e;
      if (x.rst || x.fl) begin
         q.delete();
         return;
      end
      sel  = oldest_ready();
      full = (q.size() == DEPTH);
      if (sel >= 0 && x.exr) q.delete(sel);
      if (x.cv) begin
         foreach (q[k]) begin
            if (!q[k].r1 && q[k].t1 == x.ct) begin q[k].r1 = 1'b1; q[k].v1 = x.cval; end
            if (!q[k].r2 && q[k].t2 == x.ct) begin q[k].r2 = 1'b1; q[k].v2 = x.cval; end
         end
      end
      if (x.dv && !full) begin
         e.tag = x.dtag; e.pl = x.pl; e.t1 = x.t1; e.t2 = x.t2;
         e.r1 = x.r1 || (x.cv && x.ct == x.t1);
         e.v1 = x.r1 ? x.v1 : x.cval;
         e.r2 = x.r2 || (x.cv && x.ct == x.t2);
         e.v2 = x.r2 ? x.v2 : x.cval;
         q.push_back(e);
      end
   endtask

   task automatic apply(input in_t x);
      reset = x.rst; flush = x.fl; dp_valid = x.dv; dp_tag = x.dtag;
      dp_rs1_rdy = x.r1; dp_rs1_tag = x.t1; dp_rs1_value = x.v1;
      dp_rs2_rdy = x.r2; dp_rs2_tag = x.t2; dp_rs2_value = x.v2;
      dp_payload = x.pl; cdb_valid = x.cv; cdb_tag = x.ct; cdb_value = x.cval;
      ex_ready = x.exr;
      @(negedge clock);
   endtask

   task automatic finish_cycle(input in_t x, input bit chk);
      if (chk) model_check(x);
      @(posedge clock);
      model_update(x);
      #1;
   endtask

   task automatic step(input in_t x, input bit chk);
      apply(x);
      finish_cycle(x, chk);
   endtask

   initial begin
      in_t x;

      // T1-T4 vectors, applied from an empty station
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 1,  0,0,0,0, 8,1));
      tbl.push_back(mk(1,3, 1,0,5, 1,0,7, 0,0,0, 1,  0,0,0,0, 8,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 1,  1,3,5,7, 7,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 1,  0,0,0,0, 8,1));
      tbl.push_back(mk(1,4, 0,2,0, 1,0,9, 0,0,0, 0,  0,0,0,0, 8,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,2,'h55, 0,  0,0,0,0, 7,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 1,  1,4,'h55,9, 7,1));
      tbl.push_back(mk(1,6, 0,2,0, 1,0,1, 1,2,'h66, 1,  0,0,0,0, 8,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 1,  1,6,'h66,1, 7,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 1,  0,0,0,0, 8,1));
      tbl.push_back(mk(1,1, 0,9,0, 1,0,'h10, 0,0,0, 0,  0,0,0,0, 8,1));
      tbl.push_back(mk(1,2, 1,0,'h20, 0,9,0, 0,0,0, 0,  0,0,0,0, 7,1));
      tbl.push_back(mk(1,3, 0,9,0, 0,9,0, 0,0,0, 0,  0,0,0,0, 6,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,9,'h99, 0,  0,0,0,0, 5,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,  1,1,'h99,'h10, 5,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 1,  1,1,'h99,'h10, 5,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 1,  1,2,'h20,'h99, 6,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 1,  1,3,'h99,'h99, 7,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,31,'hDEAD, 1,  0,0,0,0, 8,1));
      tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 1,  0,0,0,0, 8,1));

      x = nop(1'b0); x.rst = 1'b1;
      step(x, 1'b0);
      step(x, 1'b1);

      foreach (tbl[i]) begin
         apply(tbl[i].in);
         check($sformatf("vec%0d.is_valid", i),   is_valid,     tbl[i].e_isv);
         check($sformatf("vec%0d.is_tag", i),     is_tag,       tbl[i].e_tag);
         check($sformatf("vec%0d.is_rs1", i),     is_rs1_value, tbl[i].e_v1);
         check($sformatf("vec%0d.is_rs2", i),     is_rs2_value, tbl[i].e_v2);
         check($sformatf("vec%0d.free_count", i), free_count,   tbl[i].e_fc);
         check($sformatf("vec%0d.dp_ready", i),   dp_ready,     tbl[i].e_dpr);
         finish_cycle(tbl[i].in, 1'b1);
      end

      // T5: fill, ignored ninth dispatch, refill freed slot, drain in age order
      for (int k = 0; k < DEPTH; k++) step(disp(5'(10 + k), 32'(k), 32'(100 + k), 1'b0), 1'b1);
      x = nop(1'b0);
      apply(x);
      check("full.dp_ready", dp_ready, 0);
      check("full.free_count", free_count, 0);
      finish_cycle(x, 1'b1);
      x = disp(5'd25, 32'h25, 32'h25, 1'b0);
      apply(x);
      check("full.ninth_dp_ready", dp_ready, 0);
      finish_cycle(x, 1'b1);
      x = nop(1'b1);
      apply(x);
      check("full.oldest_tag", is_tag, 10);
      finish_cycle(x, 1'b1);
      x = nop(1'b0);
      apply(x);
      check("afterissue.dp_ready", dp_ready, 1);
      check("afterissue.free_count", free_count, 1);
      finish_cycle(x, 1'b1);
      step(disp(5'd26, 32'h26, 32'h26, 1'b0), 1'b1);
      for (int k = 0; k < DEPTH + 1; k++) step(nop(1'b1), 1'b1);

      // older entry woken later preempts a younger one that was waiting on ex_ready
      x = disp(5'd1, 0, 32'h11, 1'b0); x.r1 = 1'b0; x.t1 = 5'd8;
      step(x, 1'b1);
      step(disp(5'd2, 32'h22, 32'h23, 1'b0), 1'b1);
      x = nop(1'b0); x.cv = 1'b1; x.ct = 5'd8; x.cval = 32'h88;
      apply(x);
      check("preempt.before", is_tag, 2);
      finish_cycle(x, 1'b1);
      x = nop(1'b0);
      apply(x);
      check("preempt.after", is_tag, 1);
      check("preempt.rs1", is_rs1_value, 32'h88);
      finish_cycle(x, 1'b1);
      for (int k = 0; k < 3; k++) step(nop(1'b1), 1'b1);

      // T6: flush with five valid entries while one would issue
      for (int k = 0; k < 4; k++) step(disp(5'(1 + k), 32'(k), 32'(k), 1'b0), 1'b1);
      x = disp(5'd5, 0, 32'h5, 1'b0); x.r1 = 1'b0; x.t1 = 5'd7;
      step(x, 1'b1);
      x = disp(5'd20, 1, 1, 1'b1); x.fl = 1'b1; x.cv = 1'b1; x.ct = 5'd7; x.cval = 32'h77;
      apply(x);
      check("flush.is_valid", is_valid, 0);
      finish_cycle(x, 1'b1);
      x = nop(1'b1); x.cv = 1'b1; x.ct = 5'd7; x.cval = 32'h78;
      apply(x);
      check("flush.free_count", free_count, DEPTH);
      check("flush.is_valid_next", is_valid, 0);
      finish_cycle(x, 1'b1);
      step(nop(1'b1), 1'b1);

      // reset mid-operation, with a dispatch offered during reset
      for (int k = 0; k < 3; k++) step(disp(5'(k), 32'(k), 32'(k), 1'b0), 1'b1);
      x = disp(5'd9, 9, 9, 1'b1); x.rst = 1'b1;
      step(x, 1'b1);
      x = nop(1'b1);
      apply(x);
      check("midreset.free_count", free_count, DEPTH);
      check("midreset.is_valid", is_valid, 0);
      finish_cycle(x, 1'b1);

      // random traffic against the queue model
      for (int n = 0; n < 3000; n++) begin
         x.rst  = ($urandom_range(0, 199) == 0);
         x.fl   = ($urandom_range(0, 49) == 0);
         x.dv   = ($urandom_range(0, 9) < 6);
         x.dtag = 5'($urandom_range(0, 31));
         x.r1   = ($urandom_range(0, 1) == 0);
         x.t1   = 5'($urandom_range(0, 7));
         x.v1   = $urandom;
         x.r2   = ($urandom_range(0, 1) == 0);
         x.t2   = 5'($urandom_range(0, 7));
         x.v2   = $urandom;
         x.pl   = {$urandom, $urandom};
         x.cv   = ($urandom_range(0, 9) < 4);
         x.ct   = 5'($urandom_range(0, 7));
         x.cval = $urandom;
         x.exr  = ($urandom_range(0, 9) < 6);
         step(x, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
